// File: rtl/word_checker.sv
// word_checker: streaming word validator. Splits the character stream into words on SEP,
// checks every word against programmable "lead must be followed by follow" pair rules and
// a maximum length, and emits a registered one-cycle verdict strobe per word.
// Optional build macro: WORD_CHECKER_STATS_EN enables the ok/bad word counters; without it
// ok_count and bad_count are tied to zero.
module word_checker #(
    parameter int unsigned CHAR_W    = 8,
    parameter int unsigned NUM_RULES = 4,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned SEP       = 0,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned IDX_W    = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              rule_we,
    input  logic [IDX_W-1:0]  rule_idx,
    input  logic              rule_en,
    input  logic [CHAR_W-1:0] rule_lead,
    input  logic [CHAR_W-1:0] rule_follow,
    output logic              word_done,
    output logic              word_ok,
    output logic [1:0]        word_err,
    output logic [CNT_W-1:0]  word_len,
    output logic [CNT_W-1:0]  ok_count,
    output logic [CNT_W-1:0]  bad_count
);

    typedef enum logic [1:0] {StIdle, StInWord, StPending} state_e;

    state_e                 r_state, w_state_nxt;
    logic [NUM_RULES-1:0]   r_rule_en;
    logic [CHAR_W-1:0]      r_rule_lead   [NUM_RULES];
    logic [CHAR_W-1:0]      r_rule_follow [NUM_RULES];
    logic [NUM_RULES-1:0]   r_mask, w_mask_nxt;
    logic [CNT_W-1:0]       r_len, w_len_nxt;
    logic                   r_rerr, w_rerr_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_ok;
    logic [1:0]             r_err;
    logic [CNT_W-1:0]       r_len_out;

    logic [NUM_RULES-1:0]   w_lead_hit;
    logic [NUM_RULES-1:0]   w_follow_hit;
    logic                   w_is_sep;
    logic [CNT_W-1:0]       w_len_inc;
    logic [1:0]             w_err_fin;

    // Rule table: a write lands at the edge, so a character sampled alongside it sees old rules.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rule_en <= '0;
            for (int i = 0; i < NUM_RULES; i++) begin
                r_rule_lead[i]   <= '0;
                r_rule_follow[i] <= '0;
            end
        end else if (rule_we && (32'(rule_idx) < NUM_RULES)) begin
            r_rule_en[rule_idx]     <= rule_en;
            r_rule_lead[rule_idx]   <= rule_lead;
            r_rule_follow[rule_idx] <= rule_follow;
        end
    end

    // Per-slot match of the incoming character against leads and follows.
    always_comb begin
        for (int i = 0; i < NUM_RULES; i++) begin
            w_lead_hit[i]   = r_rule_en[i] && (r_rule_lead[i] == in_char);
            w_follow_hit[i] = (r_rule_follow[i] == in_char);
        end
    end

    assign w_is_sep  = (in_char == CHAR_W'(SEP));
    assign w_len_inc = (r_len == '1) ? r_len : r_len + CNT_W'(1);
    // A lead left pending at the separator is itself a rule violation.
    assign w_err_fin = {(32'(r_len) > MAX_LEN), (r_rerr || (r_state == StPending))};

    // Next-state: word tracking, sticky rule error, pending mask and saturating length.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_len_nxt   = r_len;
        w_rerr_nxt  = r_rerr;
        w_done_nxt  = 1'b0;
        if (in_valid) begin
            unique case (r_state)
                StIdle: begin
                    if (!w_is_sep) begin
                        w_len_nxt   = CNT_W'(1);
                        w_rerr_nxt  = 1'b0;
                        w_mask_nxt  = w_lead_hit;
                        w_state_nxt = (|w_lead_hit) ? StPending : StInWord;
                    end
                end
                StInWord, StPending: begin
                    if (w_is_sep) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = StIdle;
                        w_mask_nxt  = '0;
                        w_len_nxt   = '0;
                        w_rerr_nxt  = 1'b0;
                    end else begin
                        // Every pending slot must accept this char as its follow.
                        if ((r_state == StPending) && |(r_mask & ~w_follow_hit)) begin
                            w_rerr_nxt = 1'b1;
                        end
                        w_mask_nxt  = w_lead_hit;
                        w_state_nxt = (|w_lead_hit) ? StPending : StInWord;
                        w_len_nxt   = w_len_inc;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Word state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_mask  <= '0;
            r_len   <= '0;
            r_rerr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_len   <= w_len_nxt;
            r_rerr  <= w_rerr_nxt;
        end
    end

    // Verdict registers: strobe for one cycle, verdict fields hold until the next word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done    <= 1'b0;
            r_ok      <= 1'b0;
            r_err     <= '0;
            r_len_out <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_done_nxt) begin
                r_ok      <= (w_err_fin == 2'b00);
                r_err     <= w_err_fin;
                r_len_out <= r_len;
            end
        end
    end

    assign word_done = r_done;
    assign word_ok   = r_ok;
    assign word_err  = r_err;
    assign word_len  = r_len_out;

`ifdef WORD_CHECKER_STATS_EN
    logic [CNT_W-1:0] r_ok_cnt, r_bad_cnt;

    // Saturating pass/fail counters, updated on the same edge as the strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ok_cnt  <= '0;
            r_bad_cnt <= '0;
        end else if (w_done_nxt) begin
            if (w_err_fin == 2'b00) begin
                if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            end else begin
                if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + CNT_W'(1);
            end
        end
    end

    assign ok_count  = r_ok_cnt;
    assign bad_count = r_bad_cnt;
`else
    assign ok_count  = '0;
    assign bad_count = '0;
`endif

endmodule

// File: doc/word_checker.md
# word_checker

Streaming word validator for the character pipeline. It consumes one character per accepted cycle, splits the stream into words on a separator character, and checks each word against a small programmable set of "lead must be followed by follow" rules (e.g. Q→U) and a maximum length. It is the parametrised successor of the fixed 8-bit Q/U checker: character width, rule count and length limit are configurable, rules are runtime-programmable, and it adds a per-word verdict strobe with error cause.

## Interface

Parameters:
- CHAR_W, 8, character width in bits
- NUM_RULES, 4, number of programmable pair rules (1..16)
- MAX_LEN, 16, longest legal word in characters
- SEP, 0, separator character value
- CNT_W, 16, width of statistics counters and word_len

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  in_char is sampled this cycle
- in_char  in  CHAR_W  stream character
- rule_we  in  1  write rule slot rule_idx this cycle
- rule_idx  in  clog2(NUM_RULES)  rule slot
- rule_en  in  1  slot enable
- rule_lead  in  CHAR_W  lead character
- rule_follow  in  CHAR_W  required next character
- word_done  out  1  one-cycle verdict strobe
- word_ok  out  1  verdict, valid with word_done
- word_err  out  2  bit0 rule violation, bit1 length violation
- word_len  out  CNT_W  length of finished word (saturating)
- ok_count  out  CNT_W  words passed (stats build only)
- bad_count  out  CNT_W  words failed (stats build only)

## Operation

- Word: maximal run of non-SEP characters. Empty runs (SEP SEP) produce no verdict.
- States: IDLE (between words), IN_WORD (collecting, no pending rule), PENDING (previous char matched ≥1 enabled rule lead; pending mask holds matching slots).
- IDLE: in_char≠SEP → IN_WORD or PENDING (len=1); SEP → stay IDLE.
- IN_WORD/PENDING, non-SEP char: if PENDING, every slot in mask must have rule_follow==in_char, else set rule error (sticky). Then recompute mask from this char; mask≠0 → PENDING, else IN_WORD. len increments, saturating at 2^CNT_W−1.
- Char may itself satisfy a pending rule and be a new lead (Q U Q U legal with Q→U, U→… rules).
- SEP while PENDING: rule error (lead was last char). SEP in any word state: issue verdict, return to IDLE, clear errors/len/mask.
- Length error iff len > MAX_LEN. word_ok = (word_err==0).
- in_valid low: no state change; characters are not implied.
- Rule writes: slot updated at clock edge; a character sampled in the same cycle uses the old rule set. Mask for an already-pending slot is not re-evaluated on rewrite.
- Two enabled slots with same lead and different follow: any following char violates (documented, not guarded).

## Timing

- Reset (reset low, async): state IDLE, all rules disabled, word_done=0, word_ok=0, word_err=0, word_len=0, ok_count=0, bad_count=0.
- Verdict latency: word_done/word_ok/word_err/word_len registered, asserted the cycle after the terminating SEP is sampled, for exactly one cycle; word_ok/word_err/word_len hold until next verdict.
- Back-to-back words (x SEP y SEP) give strobes two valid cycles apart; no bubbles required.
- Reset mid-word: word discarded, no verdict, counters cleared.
- Throughput: one char per clock, no backpressure.

## Configuration

- WORD_CHECKER_STATS_EN defined: ok_count/bad_count increment on each verdict (same edge as word_done), saturating at all-ones.
- Undefined: counters not built; ok_count and bad_count tied to 0.

## Test plan

- Reset, no rules, stream 0,1,2,0 → one word_done, word_ok=1, word_err=0, word_len=2.
- Rule0 = 81→85 enabled; stream 81,1,0 → word_ok=0, word_err=2'b01, word_len=2.
- Same rule; stream 81,85,0 → word_ok=1; then 1,81,0 → word_ok=0 (lead last char), err=01.
- MAX_LEN=4; stream 1,2,3,4,5,0 → word_err=2'b10, word_len=5; stream 0,0,0 → no word_done.
- Rule written same cycle as 81 arrives → old rules apply (word passes); reset pulse mid-word → no strobe, outputs 0.
- With WORD_CHECKER_STATS_EN: 3 good + 2 bad words → ok_count=3, bad_count=2; without macro both read 0.
